// File: rtl/jt12_pcm_pkg.sv
// jt12_pcm_pkg: shared widths, max sample count and divider state
// for the PCM boxcar decimator.
package jt12_pcm_pkg;

  localparam int DW_DEF    = 9;
  localparam int STEPW_DEF = 5;
  localparam int MAX_CNT   = (1 << STEPW_DEF) - 1;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_st_e;

  function automatic int calc_aw(input int dw, input int sw);
    return dw + sw;
  endfunction

endpackage

// File: rtl/jt12_pcm_decim_if.sv
// jt12_pcm_decim_if: sample strobe, slow request and averaged output
// bundle between the mixer side and the decimator.
interface jt12_pcm_decim_if #(
  parameter int DW = 9
);

  logic                 cen55;
  logic signed [DW-1:0] pcmin;
  logic                 rd_req;
  logic signed [DW-1:0] pcmout;
  logic                 pcmout_valid;
  logic                 busy;

  modport master (
    output cen55, pcmin, rd_req,
    input  pcmout, pcmout_valid, busy
  );

  modport slave (
    input  cen55, pcmin, rd_req,
    output pcmout, pcmout_valid, busy
  );

endinterface

// File: rtl/jt12_pcm_decim_div.sv
// jt12_pcm_decim_div: restoring unsigned divider, one quotient bit per
// clk; the first bit is resolved in the start cycle itself.
module jt12_pcm_decim_div
  import jt12_pcm_pkg::*;
#(
  parameter int AW    = 14,
  parameter int stepw = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [stepw-1:0] b,
  output logic [AW-1:0]    d,
  output logic             done,
  output logic             working
);

  localparam int CW = $clog2(AW);

  div_st_e          r_st;
  div_st_e          w_st_n;
  logic [stepw-1:0] r_rem;
  logic [stepw-1:0] r_b;
  logic [AW-1:0]    r_quo;
  logic [CW-1:0]    r_cnt;
  logic [stepw-1:0] w_rem_in;
  logic [stepw-1:0] w_b;
  logic [AW-1:0]    w_quo_in;
  logic [stepw:0]   w_t;
  logic [stepw-1:0] w_sub;
  logic             w_ge;
  logic [stepw-1:0] w_rem_n;
  logic [AW-1:0]    w_quo_n;

  assign w_rem_in = start ? '0 : r_rem;
  assign w_quo_in = start ? a : r_quo;
  assign w_b      = start ? b : r_b;

  // remainder stays below b, so the low stepw bits of t-b are exact
  assign w_t     = {w_rem_in, w_quo_in[AW-1]};
  assign w_ge    = w_t >= {1'b0, w_b};
  assign w_sub   = w_t[stepw-1:0] - w_b;
  assign w_rem_n = w_ge ? w_sub : w_t[stepw-1:0];
  assign w_quo_n = {w_quo_in[AW-2:0], w_ge};

  always_ff @(posedge clk) begin
    if (rst) r_st <= IDLE;
    else     r_st <= w_st_n;
  end

  always_comb begin
    w_st_n = r_st;
    unique case (r_st)
      IDLE:    w_st_n = IDLE;
      DIV:     if (r_cnt == CW'(1)) w_st_n = DONE;
      DONE:    w_st_n = IDLE;
      default: w_st_n = IDLE;
    endcase
    if (start) w_st_n = (b == '0) ? IDLE : DIV;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_b   <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_b   <= b;
      r_cnt <= CW'(AW - 1);
    end else if (r_st == DIV) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign d       = r_quo;
  assign done    = r_st == DONE;
  assign working = r_st != IDLE;

endmodule

// File: rtl/jt12_pcm_decim.sv
// jt12_pcm_decim: boxcar-average PCM decimator closed by rd_req edges.
// JT12_PCM_DECIM_ROUND_EN selects round-half-away-from-zero.
module jt12_pcm_decim
  import jt12_pcm_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int stepw = STEPW_DEF
) (
  input logic              clk,
  input logic              rst,
  jt12_pcm_decim_if.slave  bus
);

  localparam int AW = calc_aw(DW, stepw);
`ifdef JT12_PCM_DECIM_ROUND_EN
  localparam int DVW = AW + 1;
`else
  localparam int DVW = AW;
`endif

  logic                 r_last_rd;
  logic signed [AW-1:0] r_sum;
  logic [stepw-1:0]     r_n;
  logic                 r_sign;
  logic signed [DW-1:0] r_out;
  logic                 r_valid;
  logic                 w_edge;
  logic                 w_full;
  logic signed [AW-1:0] w_samp;
  logic [AW-1:0]        w_mag;
  logic [DVW-1:0]       w_a;
  logic [DVW-1:0]       w_d;
  logic                 w_done;
  logic                 w_working;
  logic [DW-1:0]        w_q;
  logic                 w_unused;

  assign w_edge = bus.rd_req && !r_last_rd;
  assign w_full = &r_n;
  assign w_samp = {{stepw{bus.pcmin[DW-1]}}, bus.pcmin};
  assign w_mag  = r_sum[AW-1] ? -r_sum : r_sum;

`ifdef JT12_PCM_DECIM_ROUND_EN
  assign w_a = {1'b0, w_mag} + DVW'(r_n >> 1);
`else
  assign w_a = w_mag;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_rd <= 1'b0;
      r_sum     <= '0;
      r_n       <= '0;
      r_sign    <= 1'b0;
    end else begin
      r_last_rd <= bus.rd_req;
      if (w_edge) begin
        // a coincident sample opens the new window
        r_sign <= r_sum[AW-1];
        r_sum  <= bus.cen55 ? w_samp : '0;
        r_n    <= bus.cen55 ? stepw'(1) : '0;
      end else if (bus.cen55 && !w_full) begin
        r_sum <= r_sum + w_samp;
        r_n   <= r_n + stepw'(1);
      end
    end
  end

  jt12_pcm_decim_div #(
    .AW    (DVW),
    .stepw (stepw)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (w_edge),
    .a       (w_a),
    .b       (r_n),
    .d       (w_d),
    .done    (w_done),
    .working (w_working)
  );

  assign w_q      = w_d[DW-1:0];
  assign w_unused = ^w_d[DVW-1:DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_done && !w_edge) begin
        r_out   <= r_sign ? -w_q : w_q;
        r_valid <= 1'b1;
      end else if (w_edge && r_n == '0) begin
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.pcmout       = r_out;
  assign bus.pcmout_valid = r_valid;
  assign bus.busy         = (w_edge && |r_n) || w_working;

endmodule
